dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 8: the array holds 2^DEPTH_LOG2 16-bit words.
REQ-002 SHALL have parameter LATENCY, default 2: cycles from request accept to resp_valid, legal range 1..15.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, 1: the initiator presents a request.
REQ-006 SHALL have port req_ready, output, 1: the responder can accept a request.
REQ-007 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, 16: word address.
REQ-009 SHALL have port req_wdata, input, 16: store data.
REQ-010 SHALL have port resp_valid, output, 1: a response is presented.
REQ-011 SHALL have port resp_ready, input, 1: the initiator accepts the response.
REQ-012 SHALL have port resp_rdata, output, 16: load data; 16'h0000 for stores.
REQ-013 SHALL have port resp_we, output, 1: echoes req_we of the transaction being answered.
REQ-014 SHALL have port resp_err, output, 1: address error flag (see REQ-030).

Function
REQ-015 SHALL implement a three-state FSM with states IDLE, BUSY and RESP; only one transaction is outstanding at any time.
REQ-016 SHALL drive req_ready=1 only in IDLE, and resp_valid=1 only in RESP.
REQ-017 SHALL accept a request at an edge where req_valid=1 and req_ready=1, and SHALL capture req_we, req_addr and req_wdata into internal registers at that edge; later changes on the req_* inputs are ignored.
REQ-018 On accept, SHALL load a 4-bit counter with LATENCY-1 and move to BUSY.
REQ-019 In BUSY, SHALL decrement the counter each cycle and move to RESP on the edge where the counter is 0, so that resp_valid rises exactly LATENCY cycles after the accept edge.
REQ-020 For a store, SHALL write the array at the accept edge, indexed by the low DEPTH_LOG2 bits of req_addr.
REQ-021 For a load, SHALL register resp_rdata from the array on the BUSY->RESP edge, so that a load issued immediately after a store to the same address returns the new data.
REQ-022 In RESP, SHALL hold resp_valid, resp_rdata, resp_we and resp_err stable until an edge with resp_ready=1, then move to IDLE.
REQ-023 SHALL NOT raise req_ready in the cycle in which a response is accepted; the earliest next accept is the following edge, giving a minimum transaction period of LATENCY+2 cycles.
REQ-024 SHALL hold resp_valid indefinitely while resp_ready=0 (no timeout), and SHALL not lose or alter the response while doing so.
REQ-025 SHALL not reset array contents; reads of never-written words return an undefined value.

Reset
REQ-026 When rst_n=0, SHALL asynchronously force state to IDLE, the counter to 0, resp_valid=0, resp_rdata=16'h0000, resp_we=0 and resp_err=0; req_ready SHALL be 0 while rst_n=0.
REQ-027 A reset asserted during BUSY or RESP SHALL abort the transaction with no response; a store accepted before the reset remains committed.
REQ-028 After rst_n deasserts, SHALL assert req_ready from the first rising edge onward.

Configuration
REQ-029 SHALL support the macro DMEM_RESPONDER_ADDR_CHECK_EN.
REQ-030 With DMEM_RESPONDER_ADDR_CHECK_EN defined: a request with any req_addr[15:DEPTH_LOG2] bit nonzero SHALL suppress the store, return resp_rdata=16'h0000 and resp_err=1, with unchanged timing.
REQ-031 Without DMEM_RESPONDER_ADDR_CHECK_EN: upper address bits SHALL be ignored (addresses alias), resp_err SHALL be tied to 0, and no check logic SHALL be generated.

Verification
REQ-032 Reset behaviour: apply rst_n=0 mid-BUSY with LATENCY=3 -> resp_valid=0 immediately; req_ready=1 at the first edge after rst_n=1; no response for the aborted request.
REQ-033 Store then load: store 0x1234 to addr 0x0010, then load 0x0010 with resp_ready=1 -> resp_valid exactly 2 cycles after each accept; load returns resp_rdata=0x1234, resp_we=0.
REQ-034 Backpressure: hold resp_ready=0 for 5 cycles on a load of 0xBEEF -> resp_valid and resp_rdata=0xBEEF stay stable for all 5 cycles; req_ready=0 throughout; IDLE on the edge where resp_ready=1.
REQ-035 Throughput: back-to-back requests with LATENCY=1 and resp_ready tied to 1 -> one accept every 3 cycles; no request is dropped.
REQ-036 Input stability: change req_addr and req_wdata in the cycle after a store accept -> the array holds the originally captured values.
REQ-037 Address check with DEPTH_LOG2=8: store to 0x0100 -> with the macro defined, resp_err=1 and word 0x00 is unchanged; without it, resp_err=0 and word 0x00 is overwritten.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with a fixed request-to-response latency
//
// Ports:
//   clk         - single clock, all state updates on its rising edge
//   rst_n       - asynchronous active-low reset
//   req_valid   - initiator presents a request
//   req_ready   - responder can accept a request (IDLE only)
//   req_we      - 1 = store, 0 = load
//   req_addr    - 16-bit word address (low DEPTH_LOG2 bits index the array)
//   req_wdata   - store data
//   resp_valid  - response presented (RESP only)
//   resp_ready  - initiator accepts the response
//   resp_rdata  - load data, 16'h0000 for stores
//   resp_we     - echoes req_we of the transaction being answered
//   resp_err    - address error flag
//
// Optional feature: define DMEM_RESPONDER_ADDR_CHECK_EN to flag requests whose
// address bits above DEPTH_LOG2 are nonzero; such stores are suppressed and
// such loads return zero. Without it upper bits alias and resp_err is 0.
module dmem_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_rdata,
    output logic        resp_we,
    output logic        resp_err
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                state, state_nxt;
    logic [3:0]            cnt, cnt_nxt;
    logic                  running;
    logic                  cap_we;
    logic [DEPTH_LOG2-1:0] cap_idx;
    logic                  accept;
    logic                  finish;
    logic                  wr_en;
    logic [15:0]           rd_val;
    logic [15:0]           mem [2**DEPTH_LOG2];

    // running holds req_ready low during reset and raises it at the first edge after release
    assign req_ready  = running && (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;
    assign finish     = (state == BUSY) && (cnt == 4'd0);

`ifdef DMEM_RESPONDER_ADDR_CHECK_EN
    logic addr_bad;
    logic cap_bad;

    assign addr_bad = |req_addr[15:DEPTH_LOG2];
    assign wr_en    = accept && req_we && !addr_bad;
    assign rd_val   = (cap_we || cap_bad) ? 16'h0000 : mem[cap_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_bad  <= 1'b0;
            resp_err <= 1'b0;
        end else begin
            if (accept)
                cap_bad <= addr_bad;
            if (finish)
                resp_err <= cap_bad;
        end
    end
`else
    // upper address bits alias onto the array
    logic unused_addr;

    assign unused_addr = ^req_addr[15:DEPTH_LOG2];
    assign wr_en       = accept && req_we;
    assign rd_val      = cap_we ? 16'h0000 : mem[cap_idx];
    assign resp_err    = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (accept) begin
                state_nxt = BUSY;
                cnt_nxt   = 4'(LATENCY - 1);
            end
            BUSY: if (cnt == 4'd0) state_nxt = RESP;
                  else cnt_nxt = cnt - 4'd1;
            RESP: if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            running    <= 1'b0;
            cap_we     <= 1'b0;
            cap_idx    <= '0;
            resp_rdata <= 16'h0000;
            resp_we    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            running <= 1'b1;
            if (accept) begin
                cap_we  <= req_we;
                cap_idx <= req_addr[DEPTH_LOG2-1:0];
            end
            // read late so a load right after a store to the same word sees the new data
            if (finish) begin
                resp_rdata <= rd_val;
                resp_we    <= cap_we;
            end
        end
    end

    // array is not reset; a store committed at accept survives a later reset
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[req_addr[DEPTH_LOG2-1:0]] <= req_wdata;
    end
endmodule
